// File: rtl/hzd_pkg.sv
// -----------------------------------------------------------------------------
// hzd_pkg
// Shared types for the ID-stage hazard scoreboard:
//   fwd_sel_e  - two-bit forward-select encoding driven on fwdCtrl per read port
//   hzd_reg_t  - register index as stored in a shadow entry (upper bits zero)
//   shadow_t   - one pipeline shadow entry {valid, wr_reg, wr_en, is_load}
// -----------------------------------------------------------------------------
package hzd_pkg;

    // Shadow entries store indices at a fixed width so the struct can live in
    // the package; the top zero-extends REG_W-wide indices into it, so REG_W
    // must not exceed this value.
    localparam int unsigned HZD_MAX_REG_W = 8;

    typedef logic [HZD_MAX_REG_W-1:0] hzd_reg_t;

    typedef enum logic [1:0] {
        NO_FWD       = 2'b00,
        FWD_FROM_EX  = 2'b01,
        FWD_FROM_MEM = 2'b10,
        FWD_FROM_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic     valid;
        hzd_reg_t wr_reg;
        logic     wr_en;
        logic     is_load;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

endpackage

// File: rtl/hzd_port_sel.sv
// -----------------------------------------------------------------------------
// hzd_port_sel
// Forward select and load-use detection for a single ID-stage read port.
// Purely combinational.
// Ports:
//   rd_reg_i   [REG_W-1:0]  source register index
//   rd_en_i                 port reads a register
//   ex_i/mem_i/wb_i         shadow entries of the three downstream stages
//   fwd_sel_o  [1:0]        youngest matching producer, or NO_FWD
//   load_use_o              operand is produced by a load still in EX
// -----------------------------------------------------------------------------
module hzd_port_sel
    import hzd_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] rd_reg_i,
    input  logic             rd_en_i,
    input  shadow_t          ex_i,
    input  shadow_t          mem_i,
    input  shadow_t          wb_i,
    output logic [1:0]       fwd_sel_o,
    output logic             load_use_o
);

    hzd_reg_t rd_ext;
    logic     active;
    logic     hit_ex;
    logic     hit_mem;
    logic     hit_wb;

    // r0 is hard-wired zero, so it never needs (or may take) a forwarded value.
    assign rd_ext  = hzd_reg_t'(rd_reg_i);
    assign active  = rd_en_i && (rd_reg_i != '0);
    assign hit_ex  = ex_i.valid  && ex_i.wr_en  && (ex_i.wr_reg  == rd_ext);
    assign hit_mem = mem_i.valid && mem_i.wr_en && (mem_i.wr_reg == rd_ext);
    assign hit_wb  = wb_i.valid  && wb_i.wr_en  && (wb_i.wr_reg  == rd_ext);

    // NOTE: every output of an always_comb block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        fwd_sel_o  = NO_FWD;
        load_use_o = 1'b0;
        if (active) begin
            // Youngest producer wins: EX holds the most recent write.
            if (hit_ex) begin
                fwd_sel_o = FWD_FROM_EX;
            end else if (hit_mem) begin
                fwd_sel_o = FWD_FROM_MEM;
            end else if (hit_wb) begin
                fwd_sel_o = FWD_FROM_WB;
            end
            load_use_o = hit_ex && ex_i.is_load;
        end
    end

    // The load flag only matters in EX; older stages carry it along unused.
    logic unused_load_bits;
    assign unused_load_bits = &{1'b0, mem_i.is_load, wb_i.is_load};

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// ID-stage hazard unit for an in-order pipeline: forward selects for each
// read port, load-use stall, and a pending-register scoreboard for
// long-latency (mul/div) ops that complete out of band.
// Optional feature macro: HZD_STATS_EN adds a saturating 16-bit stall counter.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_valid                    ID holds a valid instruction
//   id_rdReg  [NUM_RD*REG_W-1:0] source indices, port i at [i*REG_W +: REG_W]
//   id_rdEn   [NUM_RD-1:0]      per-port read enable
//   id_wrReg, id_wrEn           destination index / destination written
//   id_isLoad, id_isLong        memory load / long-latency op
//   flush                       kill the ID instruction this cycle
//   long_done, long_wrReg       long unit write-back and its destination
//   fwdCtrl   [2*NUM_RD-1:0]    per-port forward select, port i at [2i+1:2i]
//   stall                       hold PC/ID, inject a bubble into EX
//   long_busy                   at least one long op outstanding (registered)
//   stall_cnt [15:0]            cycles with stall=1 (HZD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hzd_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int REG_W      = 4,
    parameter int LONG_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NUM_RD*REG_W-1:0] id_rdReg,
    input  logic [NUM_RD-1:0]       id_rdEn,
    input  logic [REG_W-1:0]        id_wrReg,
    input  logic                    id_wrEn,
    input  logic                    id_isLoad,
    input  logic                    id_isLong,
    input  logic                    flush,
    input  logic                    long_done,
    input  logic [REG_W-1:0]        long_wrReg,
    output logic [2*NUM_RD-1:0]     fwdCtrl,
    output logic                    stall,
    output logic                    long_busy
`ifdef HZD_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int NUM_REGS = 2 ** REG_W;
    localparam int CNT_W    = $clog2(LONG_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LONG_DEPTH);

    shadow_t             ex_q, ex_d, mem_q, wb_q;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    out_q, out_d;
    logic                long_busy_q;

    logic [NUM_RD-1:0]   load_use_hit;
    logic                raw_hit;
    logic                waw_hit;
    logic                long_full;
    logic                id_take;
    logic                long_accept;
    logic                done_ok;

    // ---------------- per-port forwarding / load-use ----------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        hzd_port_sel #(.REG_W(REG_W)) u_port_sel (
            .rd_reg_i   (id_rdReg[i*REG_W +: REG_W]),
            .rd_en_i    (id_rdEn[i]),
            .ex_i       (ex_q),
            .mem_i      (mem_q),
            .wb_i       (wb_q),
            .fwd_sel_o  (fwdCtrl[2*i +: 2]),
            .load_use_o (load_use_hit[i])
        );
    end

    // ---------------- scoreboard hazards ----------------
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            raw_hit = raw_hit
                    | (id_rdEn[i]
                       && (id_rdReg[i*REG_W +: REG_W] != '0)
                       && pend_q[id_rdReg[i*REG_W +: REG_W]]);
        end
    end

    assign waw_hit   = id_wrEn && pend_q[id_wrReg];
    assign long_full = id_isLong && (out_q == CNT_FULL);

    // An empty ID slot never stalls; flush is applied independently of stall.
    assign stall       = id_valid && ((|load_use_hit) || raw_hit || waw_hit || long_full);
    assign id_take     = id_valid && !stall && !flush;
    assign long_accept = id_take && id_isLong && id_wrEn;
    // A completion with nothing outstanding is stale (e.g. issued before a reset).
    assign done_ok     = long_done && (out_q != '0);

    // ---------------- next state ----------------
    always_comb begin
        ex_d = SHADOW_BUBBLE;
        if (id_take) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_reg  = hzd_reg_t'(id_wrReg);
            // Long ops write back through the scoreboard, not the pipeline.
            ex_d.wr_en   = id_wrEn && !id_isLong;
            ex_d.is_load = id_isLoad;
        end

        pend_d = pend_q;
        if (done_ok) begin
            pend_d[long_wrReg] = 1'b0;
        end
        if (long_accept && (id_wrReg != '0)) begin
            pend_d[id_wrReg] = 1'b1;
        end

        out_d = out_q;
        unique case ({long_accept, done_ok})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, making MEM<=EX and WB<=MEM order-independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= SHADOW_BUBBLE;
            mem_q       <= SHADOW_BUBBLE;
            wb_q        <= SHADOW_BUBBLE;
            pend_q      <= '0;
            out_q       <= '0;
            long_busy_q <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            pend_q      <= pend_d;
            out_q       <= out_d;
            // Registered from the next count so it tracks out_q with no lag.
            long_busy_q <= (out_d != '0);
        end
    end

    assign long_busy = long_busy_q;

`ifdef HZD_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard (default parameters). Each cycle's
// expected {fwdCtrl, stall, long_busy} is queued when the ID inputs are driven
// and popped/compared at the following negedge. Build with +define+HZD_STATS_EN
// to also exercise the stall counter.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [7:0] id_rdReg;
    logic [1:0] id_rdEn;
    logic [3:0] id_wrReg;
    logic       id_wrEn;
    logic       id_isLoad;
    logic       id_isLong;
    logic       flush;
    logic       long_done;
    logic [3:0] long_wrReg;
    logic [3:0] fwdCtrl;
    logic       stall;
    logic       long_busy;
`ifdef HZD_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    string      tag_q[$];
    logic [5:0] exp_q[$];

    hazard_scoreboard #(
        .NUM_RD(2), .REG_W(4), .LONG_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rdReg   (id_rdReg),
        .id_rdEn    (id_rdEn),
        .id_wrReg   (id_wrReg),
        .id_wrEn    (id_wrEn),
        .id_isLoad  (id_isLoad),
        .id_isLong  (id_isLong),
        .flush      (flush),
        .long_done  (long_done),
        .long_wrReg (long_wrReg),
        .fwdCtrl    (fwdCtrl),
        .stall      (stall),
        .long_busy  (long_busy)
`ifdef HZD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one ID instruction; clears flush and long_done.
    task automatic set_id(input logic v,
                          input logic [3:0] r0, input logic e0,
                          input logic [3:0] r1, input logic e1,
                          input logic [3:0] wr, input logic we,
                          input logic ld, input logic lg);
        id_valid   = v;
        id_rdReg   = {r1, r0};
        id_rdEn    = {e1, e0};
        id_wrReg   = wr;
        id_wrEn    = we;
        id_isLoad  = ld;
        id_isLong  = lg;
        flush      = 1'b0;
        long_done  = 1'b0;
        long_wrReg = 4'd0;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation for the cycle just driven, compare at negedge,
    // then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] efwd,
                       input logic estall, input logic ebusy);
        string      t;
        logic [5:0] e;
        tag_q.push_back(tag);
        exp_q.push_back({efwd, estall, ebusy});
        @(negedge clk);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check({t, "_fwd"},   16'(fwdCtrl),   16'(e[5:2]));
        check({t, "_stall"}, 16'(stall),     16'(e[1]));
        check({t, "_busy"},  16'(long_busy), 16'(e[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle();                                           cyc("rst_state",   4'b0000, 0, 0);

        // Forwarding priority EX > MEM > WB, r0 never forwarded.
        set_id(1, 0,0, 0,0, 3,1, 0,0);                    cyc("alu_r3",      4'b0000, 0, 0);
        set_id(1, 3,1, 0,0, 3,1, 0,0);                    cyc("fwd_ex",      4'b0001, 0, 0);
        set_id(1, 3,1, 0,1, 0,1, 0,0);                    cyc("ex_prio",     4'b0001, 0, 0);
        set_id(1, 3,1, 0,1, 0,1, 0,0);                    cyc("fwd_mem",     4'b0010, 0, 0);
        set_id(1, 3,1, 0,1, 0,1, 0,0);                    cyc("fwd_wb",      4'b0011, 0, 0);
        set_id(1, 0,1, 0,1, 0,0, 0,0);                    cyc("r0_never",    4'b0000, 0, 0);

        // Load-use: one stall cycle, bubble, then forward from MEM.
        set_id(1, 0,0, 0,0, 5,1, 1,0);                    cyc("load_r5",     4'b0000, 0, 0);
        set_id(1, 5,1, 0,0, 6,1, 0,0);                    cyc("load_use",    4'b0001, 1, 0);
        set_id(1, 5,1, 0,0, 6,1, 0,0);                    cyc("after_bub",   4'b0010, 0, 0);
        set_id(1, 5,1, 6,1, 0,0, 0,0);                    cyc("wb_and_ex",   4'b0111, 0, 0);
        set_id(1, 6,0, 6,1, 0,0, 0,0);                    cyc("rden_gate",   4'b1000, 0, 0);

        // Long op RAW: stall until the cycle after long_done.
        set_id(1, 0,0, 0,0, 7,1, 0,1);                    cyc("long_r7",     4'b0000, 0, 0);
        set_id(1, 7,1, 0,0, 8,1, 0,0);                    cyc("raw_stall",   4'b0000, 1, 1);
        set_id(0, 7,1, 0,0, 8,1, 0,0);                    cyc("no_valid",    4'b0000, 0, 1);
        set_id(1, 7,1, 0,0, 8,1, 0,0);
        long_done = 1'b1; long_wrReg = 4'd7;              cyc("done_cycle",  4'b0000, 1, 1);
        set_id(1, 7,1, 0,0, 8,1, 0,0);                    cyc("raw_clear",   4'b0000, 0, 0);

        // WAW on a pending destination.
        set_id(1, 0,0, 0,0, 9,1, 0,1);                    cyc("long_r9",     4'b0000, 0, 0);
        set_id(1, 0,0, 0,0, 9,1, 0,0);                    cyc("waw_stall",   4'b0000, 1, 1);

        // Capacity limit and simultaneous accept/done.
        set_id(1, 0,0, 0,0, 10,1, 0,1);                   cyc("long_r10",    4'b0000, 0, 1);
        set_id(1, 0,0, 0,0, 11,1, 0,1);                   cyc("full_stall",  4'b0000, 1, 1);
        set_id(1, 0,0, 0,0, 11,1, 0,1);
        long_done = 1'b1; long_wrReg = 4'd9;              cyc("full_done",   4'b0000, 1, 1);
        set_id(1, 0,0, 0,0, 11,1, 0,1);                   cyc("full_accept", 4'b0000, 0, 1);
        set_id(1, 0,0, 0,0, 12,1, 0,1);                   cyc("full_again",  4'b0000, 1, 1);
        idle(); long_done = 1'b1; long_wrReg = 4'd10;     cyc("drain_r10",   4'b0000, 0, 1);
        set_id(1, 0,0, 0,0, 12,1, 0,1);
        long_done = 1'b1; long_wrReg = 4'd11;             cyc("acc_and_done",4'b0000, 0, 1);
        set_id(1, 12,1, 0,0, 0,0, 0,0);                   cyc("r12_pending", 4'b0000, 1, 1);
        idle(); long_done = 1'b1; long_wrReg = 4'd12;     cyc("drain_r12",   4'b0000, 0, 1);
        idle();                                           cyc("idle_empty",  4'b0000, 0, 0);

        // Completion with nothing outstanding is ignored.
        idle(); long_done = 1'b1; long_wrReg = 4'd3;      cyc("spur_done",   4'b0000, 0, 0);
        idle();                                           cyc("no_underflow",4'b0000, 0, 0);

        // Flush kills the ID instruction.
        set_id(1, 0,0, 0,0, 13,1, 0,0); flush = 1'b1;     cyc("flush_alu",   4'b0000, 0, 0);
        set_id(1, 13,1, 0,0, 0,0, 0,0);                   cyc("flushed_gone",4'b0000, 0, 0);
        set_id(1, 0,0, 0,0, 14,1, 0,1); flush = 1'b1;     cyc("flush_long",  4'b0000, 0, 0);
        set_id(1, 14,1, 0,0, 0,0, 0,0);                   cyc("flush_nopend",4'b0000, 0, 0);

        // Reset mid-operation drops pending work and shadow entries.
        set_id(1, 0,0, 0,0, 2,1, 0,0);                    cyc("alu_r2",      4'b0000, 0, 0);
        set_id(1, 2,1, 0,0, 15,1, 0,1);                   cyc("long_r15",    4'b0001, 0, 0);
        set_id(1, 15,1, 0,0, 0,0, 0,0);                   cyc("pre_rst",     4'b0000, 1, 1);
        pulse_rst();
        set_id(1, 2,1, 15,1, 0,0, 0,0);                   cyc("post_rst",    4'b0000, 0, 0);
        idle(); long_done = 1'b1; long_wrReg = 4'd15;     cyc("stale_done",  4'b0000, 0, 0);
        idle();                                           cyc("stale_ign",   4'b0000, 0, 0);

`ifdef HZD_STATS_EN
        pulse_rst();
        set_id(1, 0,0, 0,0, 1,1, 0,1);                    cyc("st_long",     4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) begin
            set_id(1, 1,1, 0,0, 0,0, 0,0);                cyc("st_stall",    4'b0000, 1, 1);
        end
        idle(); long_done = 1'b1; long_wrReg = 4'd1;      cyc("st_done",     4'b0000, 0, 1);
        @(negedge clk);
        check("stall_cnt_5", stall_cnt, 16'd5);
        @(posedge clk);
        #1;
        pulse_rst();
        @(negedge clk);
        check("stall_cnt_rst", stall_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_RD, default 2, number of ID-stage read ports.
REQ-002 Parameter REG_W, default 4, register-index width; NUM_REGS = 2**REG_W.
REQ-003 Parameter LONG_DEPTH, default 2, max outstanding long-latency ops.
REQ-004 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid  in  1  ID holds a valid instruction.
REQ-008 id_rdReg  in  NUM_RD*REG_W  source indices, port i at bits [i*REG_W +: REG_W].
REQ-009 id_rdEn  in  NUM_RD  per-port read enable.
REQ-010 id_wrReg  in  REG_W  destination index; id_wrEn  in  1  destination written.
REQ-011 id_isLoad  in  1  memory load; id_isLong  in  1  long-latency op (mul/div).
REQ-012 flush  in  1  kill the ID instruction this cycle.
REQ-013 long_done  in  1  long unit writes back this cycle; long_wrReg  in  REG_W  its destination.
REQ-014 fwdCtrl  out  2*NUM_RD  per-port forward select, port i at [2i+1:2i].
REQ-015 stall  out  1  hold PC/ID, inject bubble into EX.
REQ-016 long_busy  out  1  at least one long op outstanding.

Function
REQ-017 Shadow entries EX, MEM, WB SHALL each hold {valid, wrReg, wrEn, isLoad} and advance every cycle: MEM<=EX, WB<=MEM.
REQ-018 EX SHALL load the ID fields when id_valid & !stall & !flush, else a bubble (valid=0); a long op SHALL load with wrEn=0.
REQ-019 fwdCtrl port i SHALL be combinational, zero latency: NO_FWD if index 0 or !id_rdEn[i]; else first valid&wrEn match in order EX, MEM, WB; else NO_FWD.
REQ-020 Load-use: stall SHALL assert when an enabled nonzero port matches a valid EX entry with isLoad & wrEn.
REQ-021 Scoreboard pend[NUM_REGS] SHALL set bit id_wrReg when a long op is accepted (id_valid & id_isLong & id_wrEn & !stall & !flush, wrReg!=0).
REQ-022 pend bit long_wrReg SHALL clear at the edge ending the long_done cycle; ID sees it clear the next cycle.
REQ-023 stall SHALL assert on RAW (enabled nonzero source pending) or WAW (id_wrEn & pend[id_wrReg]).
REQ-024 Counter outstanding (0..LONG_DEPTH): +1 on accept, -1 on long_done; simultaneous both SHALL leave it unchanged.
REQ-025 stall SHALL assert when id_isLong & outstanding==LONG_DEPTH.
REQ-026 long_done with outstanding==0 SHALL be ignored (no underflow, pend unchanged).
REQ-027 stall SHALL be 0 whenever id_valid=0; flush SHALL not be masked by stall.
REQ-028 long_busy SHALL equal (outstanding!=0), registered.

Reset
REQ-029 rst SHALL clear all shadow valid bits, pend, outstanding; next cycle fwdCtrl=all NO_FWD, stall=0 (with id_valid=0), long_busy=0.
REQ-030 rst mid-operation SHALL drop all pending long ops; later long_done SHALL be ignored per REQ-026.

Configuration
REQ-031 Macro HZD_STATS_EN: when defined, output stall_cnt (16 bits) SHALL count cycles with stall=1, saturating at 0xFFFF, reset to 0.
REQ-032 Without HZD_STATS_EN the stall_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package hzd_pkg SHALL hold forward encodings NO_FWD=2'b00, FWD_FROM_EX=2'b01, FWD_FROM_MEM=2'b10, FWD_FROM_WB=2'b11 and the shadow-entry struct type.
REQ-034 Sub-module hzd_port_sel SHALL compute one port's fwdCtrl and load-use hit; instantiated NUM_RD times.

Verification
REQ-035 EX wrReg=3 wrEn=1, MEM wrReg=3, ID port0 reads r3 -> fwdCtrl[1:0]=01 (EX priority), stall=0.
REQ-036 Port1 reads r0, EX/MEM/WB all write r0 -> fwdCtrl[3:2]=00.
REQ-037 Load to r5 enters EX, next ID reads r5 -> stall=1 one cycle, bubble in EX, then fwdCtrl=10 (MEM), stall=0.
REQ-038 Long op to r7 accepted, ID reads r7 -> stall held until cycle after long_done with long_wrReg=7, then stall=0, long_busy=0.
REQ-039 LONG_DEPTH=2, two long ops outstanding, third long op in ID -> stall=1; long_done same cycle -> third accepted next cycle, outstanding stays 2.
REQ-040 HZD_STATS_EN defined, 5 stall cycles then rst -> stall_cnt=5 before rst, 0 after.
